// File: rtl/cv32e41p_fetch_sequencer.sv
// Instruction-fetch request sequencer: issues word-aligned OBI requests, tracks
// outstanding transactions and FIFO credit, and discards responses from before a branch.
module cv32e41p_fetch_sequencer #(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_i,
    input  logic                       branch_i,
    input  logic [31:0]                branch_addr_i,
    input  logic [$clog2(DEPTH):0]     fifo_cnt_i,
    output logic                       trans_valid_o,
    input  logic                       trans_ready_i,
    output logic [31:0]                trans_addr_o,
    input  logic                       resp_valid_i,
    output logic                       fetch_valid_o,
    output logic                       busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 3;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_GNT_BR} state_t;

    state_t        state_q, state_next;
    logic [1:0]    cnt_q, cnt_next;
    logic [1:0]    flush_q, flush_next;
    logic [1:0]    flush_dec, flush_br;
    logic [29:0]   addr_q, addr_next;
    logic [29:0]   br_q, br_next;
    logic [29:0]   target, req_word;
    logic [CW-1:0] occ;
    logic [SW-1:0] used;
    logic          issue_ok, valid_int, hs;

    always_comb begin
        state_next = state_q;
        addr_next  = addr_q;
        br_next    = br_q;
        req_word   = addr_q;
        valid_int  = 1'b0;
        target     = branch_addr_i[31:2];
        occ        = branch_i ? '0 : fifo_cnt_i;
        used       = SW'(occ) + SW'(cnt_q) - SW'(flush_q);
        issue_ok   = req_i && (cnt_q < 2'(MAX_OUTSTANDING)) && (used < SW'(DEPTH));
        flush_dec  = (resp_valid_i && flush_q != 2'd0) ? flush_q - 2'd1 : flush_q;
        // A response arriving in the branch cycle is dropped, so it is not owed.
        flush_br   = cnt_q - {1'b0, resp_valid_i};
        flush_next = flush_dec;

        case (state_q)
            IDLE: begin
                valid_int = issue_ok;
                if (branch_i) begin
                    req_word   = target;
                    flush_next = flush_br;
                end
                if (issue_ok && trans_ready_i) begin
                    addr_next = req_word + 30'd1;
                end else begin
                    addr_next = req_word;
                    if (issue_ok) state_next = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                valid_int = 1'b1;
                if (trans_ready_i) begin
                    state_next = IDLE;
                    if (branch_i) begin
                        addr_next  = target;
                        flush_next = flush_br + 2'd1;
                    end else begin
                        addr_next = addr_q + 30'd1;
                    end
                end else if (branch_i) begin
                    br_next    = target;
                    flush_next = flush_br;
                    state_next = WAIT_GNT_BR;
                end
            end
            WAIT_GNT_BR: begin
                valid_int = 1'b1;
                if (branch_i) begin
                    br_next    = target;
                    flush_next = flush_br;
                end
                if (trans_ready_i) begin
                    // The granted word belongs to the old path and is owed too.
                    flush_next = flush_next + 2'd1;
                    addr_next  = branch_i ? target : br_q;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        hs       = valid_int && trans_ready_i;
        cnt_next = cnt_q + {1'b0, hs} - {1'b0, resp_valid_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= '0;
            addr_q  <= '0;
            br_q    <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            flush_q <= flush_next;
            addr_q  <= addr_next;
            br_q    <= br_next;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign trans_valid_o = rst_n && valid_int;
    assign trans_addr_o  = rst_n ? {req_word, 2'b00} : 32'h0;
    assign fetch_valid_o = rst_n && resp_valid_i && (flush_q == 2'd0) && !branch_i;
    assign busy_o        = rst_n && ((cnt_q != 2'd0) || (state_q != IDLE));

    a_no_spurious_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_valid_i && cnt_q == 2'd0));
    a_branch_halfword: assert property (@(posedge clk) disable iff (!rst_n)
        !branch_i || (branch_addr_i[1:0] != 2'b01 && branch_addr_i[1:0] != 2'b11));

endmodule

// File: doc/cv32e41p_fetch_sequencer.md
Name: cv32e41p_fetch_sequencer

Overview:
Issues word-aligned instruction-memory requests (OBI-style valid/ready request, response-valid) on behalf of the IF stage, feeding the prefetch FIFO that drives the instruction aligner. It tracks outstanding transactions, enforces FIFO credit, and redirects on branches. Responses to transactions issued before a branch are discarded, so the aligner only sees words on the new path.

Parameters:
DEPTH, 2, prefetch FIFO depth in words.
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions. Range 1..3.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_i  input  1  fetch enable from the IF controller
branch_i  input  1  redirect request, single-cycle pulse
branch_addr_i  input  32  redirect target; halfword-aligned, bit 1 may be set
fifo_cnt_i  input  $clog2(DEPTH)+1  current prefetch FIFO occupancy
trans_valid_o  output  1  memory request valid
trans_ready_i  input  1  memory request accepted (grant)
trans_addr_o  output  32  request address, bits [1:0] always 0
resp_valid_i  input  1  memory response valid
fetch_valid_o  output  1  response valid to FIFO/aligner, excluding discarded responses
busy_o  output  1  outstanding count nonzero or request pending

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, evaluated at the clk edge.
- Reset values: trans_valid_o=0, trans_addr_o=0, fetch_valid_o=0, busy_o=0, cnt_q=0, flush_q=0, state=IDLE, addr_q=0.
- Handshake: a transaction occurs when trans_valid_o && trans_ready_i. While trans_valid_o=1 and trans_ready_i=0, trans_addr_o and trans_valid_o hold stable. This must hold even across a branch.
- Outstanding counter cnt_q:
  - +1 on handshake, -1 on resp_valid_i, both in the same cycle gives net 0.
  - Never exceeds MAX_OUTSTANDING.
  - A resp_valid_i while cnt_q=0 is illegal (assertion).
- Discard counter flush_q: counts responses still owed by pre-branch transactions.
  - fetch_valid_o = resp_valid_i && flush_q==0 && !branch_i.
  - flush_q decrements on resp_valid_i while nonzero.
- Credit rule: issue allowed when req_i && cnt_q<MAX_OUTSTANDING && (occ + cnt_q - flush_q) < DEPTH.
  - occ = 0 in the branch cycle (the FIFO is flushed by IF); otherwise occ = fifo_cnt_i.
- Address: trans_addr_o = {addr_q[31:2],2'b00}.
  - After each handshake, addr_q <= trans_addr_o + 4. This wraps from 0xFFFF_FFFC to 0x0000_0000.
- State machine:
  - IDLE:
    - trans_valid_o = issue-allowed.
    - Handshake stays in IDLE.
    - Valid without ready goes to WAIT_GNT.
    - On branch_i: addr_q <= branch_addr_i with bits [1:0] cleared; flush_q <= cnt_q - resp_valid_i. If issue is allowed, the branch address is driven combinationally in the same cycle.
  - WAIT_GNT:
    - trans_valid_o=1 and address held.
    - On grant, go to IDLE.
    - On branch_i without grant: latch the target into br_q and go to WAIT_GNT_BR.
    - On branch_i with grant: same as the IDLE branch, except flush_q additionally counts the granted transaction.
  - WAIT_GNT_BR:
    - Old address held with trans_valid_o=1.
    - On grant: flush_q increments to count that transaction, addr_q <= br_q, then go to IDLE.
    - A further branch_i overwrites br_q; the latest target wins.
- req_i deassertion:
  - In IDLE it stops new requests.
  - In WAIT_GNT or WAIT_GNT_BR, the pending request is completed; the request is not withdrawn.
- Simultaneous branch and resp_valid_i: that response is discarded and not counted into flush_q.
- Reset mid-transaction clears all counters and state. The environment guarantees no stale responses after reset.
- busy_o = cnt_q!=0 || state!=IDLE.
- Latency: the first request is issued combinationally in the cycle req_i rises from IDLE with credit available (0-cycle request latency).

Test Plan:
- Reset, req_i=1, trans_ready_i=1, responses 1 cycle later, fifo_cnt_i=0 -> addresses 0x0, 0x4, 0x8; cnt_q never exceeds 2; fetch_valid_o follows each resp_valid_i.
- fifo_cnt_i=1, DEPTH=2, cnt_q=1 -> trans_valid_o=0 until the response arrives and fifo_cnt_i drops to 0.
- Two outstanding transactions, branch_i to 0x102 -> next trans_addr_o=0x100; the next 2 resp_valid_i give fetch_valid_o=0; the third gives fetch_valid_o=1.
- trans_ready_i=0 with a pending request at 0x8, branch_i to 0x200 -> trans_addr_o stays 0x8 until grant; next request is 0x200; the response for 0x8 is discarded.
- Two branches (0x300, then 0x400) while a grant is stalled -> the only post-grant request goes to 0x400.
- addr_q=0xFFFF_FFFC, handshake -> next trans_addr_o=0x0000_0000. Assert rst_n=0 mid-burst -> all outputs 0 at the next clk edge.
